// File: rtl/menu_selector.sv
// N-option menu controller: debounced prev/next/confirm buttons, wrap-around cursor, one-cycle commit, glyph display.
// Optional idle auto-commit is enabled with `define MENU_TIMEOUT_EN.
module menu_selector #(
    parameter int unsigned         N_OPT       = 4,
    parameter int unsigned         IDX_W       = 4,
    parameter int unsigned         DEB_CYC     = 500000,
    parameter int unsigned         DEFAULT_OPT = 2,
    parameter logic [N_OPT*36-1:0] OPT_GLYPHS  = '0,
    parameter logic [35:0]         IDLE_GLYPH  = 36'h28A28A28A,
    parameter int unsigned         TIMEOUT_CYC = 1 << 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             open,
    input  logic             preMode,
    input  logic             nextMode,
    input  logic             confirm,
    output logic             busy,
    output logic             sel_valid,
    output logic [N_OPT-1:0] sel_onehot,
    output logic [IDX_W-1:0] sel_idx,
    output logic             sel_timeout,
    output logic [IDX_W-1:0] cursor,
    output logic [5:0]       Seg1,
    output logic [5:0]       Seg2,
    output logic [5:0]       Seg3,
    output logic [5:0]       Seg4,
    output logic [5:0]       Seg5,
    output logic [5:0]       Seg6
);

    localparam int unsigned N_BTN = 3;
    localparam int unsigned DEB_W = $clog2(DEB_CYC);
    localparam int unsigned GW    = 36;

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        BROWSE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state;
    logic [N_BTN-1:0] raw;
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] ev;
    logic [DEB_W-1:0] deb_cnt [N_BTN];
    logic             open_q;
    logic             open_rise;
    logic             open_fall;
    logic             ev_pre;
    logic             ev_next;
    logic             ev_conf;
    logic [IDX_W-1:0] cur_inc;
    logic [IDX_W-1:0] cur_dec;
    logic [GW-1:0]    seg_word;

    assign raw     = {confirm, nextMode, preMode};
    assign ev_pre  = ev[0];
    assign ev_next = ev[1];
    assign ev_conf = ev[2];

    // Synchronise, then accept a new level only after DEB_CYC stable cycles; ev pulses on accepted rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            ev    <= '0;
            for (int i = 0; i < int'(N_BTN); i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            ev    <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
                    level[i]   <= sync2[i];
                    ev[i]      <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) open_q <= 1'b0;
        else        open_q <= open;
    end

    assign open_rise = open & ~open_q;
    assign open_fall = ~open & open_q;

    assign cur_inc = (cursor == IDX_W'(N_OPT - 1)) ? '0 : cursor + 1'b1;
    assign cur_dec = (cursor == '0) ? IDX_W'(N_OPT - 1) : cursor - 1'b1;

`ifdef MENU_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);

    logic [TO_W-1:0] idle_cnt;
    logic            timeout_hit;

    assign timeout_hit = (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Idle cycles spent in BROWSE since entry or the last button event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      idle_cnt <= '0;
        else if (state != BROWSE || |ev) idle_cnt <= '0;
        else if (!timeout_hit)           idle_cnt <= idle_cnt + 1'b1;
    end
`else
    logic timeout_unused;

    assign timeout_unused = ^TIMEOUT_CYC;
    assign sel_timeout    = 1'b0;
`endif

    // Menu FSM; close beats confirm, confirm beats movement, opposing moves cancel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLOSED;
            busy       <= 1'b0;
            sel_valid  <= 1'b0;
            sel_onehot <= '0;
            sel_idx    <= IDX_W'(DEFAULT_OPT);
            cursor     <= IDX_W'(DEFAULT_OPT);
            seg_word   <= IDLE_GLYPH;
`ifdef MENU_TIMEOUT_EN
            sel_timeout <= 1'b0;
`endif
        end else begin
            sel_valid  <= 1'b0;
            sel_onehot <= '0;
`ifdef MENU_TIMEOUT_EN
            sel_timeout <= 1'b0;
`endif
            case (state)
                CLOSED: begin
                    if (open_rise) begin
                        state  <= BROWSE;
                        busy   <= 1'b1;
                        cursor <= IDX_W'(DEFAULT_OPT);
                    end
                end
                BROWSE: begin
                    if (open_fall) begin
                        state <= CLOSED;
                        busy  <= 1'b0;
                    end else if (ev_conf) begin
                        state      <= COMMIT;
                        busy       <= 1'b0;
                        sel_valid  <= 1'b1;
                        sel_onehot <= N_OPT'(1) << cursor;
                        sel_idx    <= cursor;
                    end
`ifdef MENU_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state       <= COMMIT;
                        busy        <= 1'b0;
                        cursor      <= IDX_W'(DEFAULT_OPT);
                        sel_valid   <= 1'b1;
                        sel_timeout <= 1'b1;
                        sel_onehot  <= N_OPT'(1) << DEFAULT_OPT;
                        sel_idx     <= IDX_W'(DEFAULT_OPT);
                    end
`endif
                    else if (ev_next && !ev_pre) begin
                        cursor <= cur_inc;
                    end else if (ev_pre && !ev_next) begin
                        cursor <= cur_dec;
                    end
                end
                COMMIT: begin
                    state <= CLOSED;
                end
                default: begin
                    state <= CLOSED;
                    busy  <= 1'b0;
                end
            endcase
            seg_word <= (state == CLOSED) ? IDLE_GLYPH : OPT_GLYPHS[GW*int'(cursor) +: GW];
        end
    end

    assign Seg1 = seg_word[35:30];
    assign Seg2 = seg_word[29:24];
    assign Seg3 = seg_word[23:18];
    assign Seg4 = seg_word[17:12];
    assign Seg5 = seg_word[11:6];
    assign Seg6 = seg_word[5:0];

endmodule

// File: tb/tb_menu_selector.sv
// Scoreboard bench for menu_selector: directed button sequences, commits checked by a sel_valid monitor.
module tb_menu_selector;

    localparam int unsigned N_OPT   = 4;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned DEB_CYC = 4;
    localparam int unsigned DEF_OPT = 2;
    localparam int unsigned TO_CYC  = 64;
    localparam logic [35:0] G0      = 36'h111111111;
    localparam logic [35:0] G1      = 36'h2A2A2A2A2;
    localparam logic [35:0] G2      = 36'h3C3C3C3C3;
    localparam logic [35:0] G3      = 36'h456789ABC;
    localparam logic [143:0] GLYPHS = {G3, G2, G1, G0};
    localparam logic [35:0] IDLE    = 36'h28A28A28A;

    logic             clk;
    logic             rst_n;
    logic             open;
    logic             preMode;
    logic             nextMode;
    logic             confirm;
    logic             busy;
    logic             sel_valid;
    logic [N_OPT-1:0] sel_onehot;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_timeout;
    logic [IDX_W-1:0] cursor;
    logic [5:0]       Seg1, Seg2, Seg3, Seg4, Seg5, Seg6;

    typedef struct packed {
        logic [3:0] onehot;
        logic [3:0] idx;
        logic       tmo;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    menu_selector #(
        .N_OPT(N_OPT), .IDX_W(IDX_W), .DEB_CYC(DEB_CYC), .DEFAULT_OPT(DEF_OPT),
        .OPT_GLYPHS(GLYPHS), .IDLE_GLYPH(IDLE), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .open(open), .preMode(preMode), .nextMode(nextMode),
        .confirm(confirm), .busy(busy), .sel_valid(sel_valid), .sel_onehot(sel_onehot),
        .sel_idx(sel_idx), .sel_timeout(sel_timeout), .cursor(cursor),
        .Seg1(Seg1), .Seg2(Seg2), .Seg3(Seg3), .Seg4(Seg4), .Seg5(Seg5), .Seg6(Seg6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [35:0] glyph(input int k);
        logic [143:0] t;
        t = GLYPHS;
        return t[k*36 +: 36];
    endfunction

    // Monitor: every committed selection must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && sel_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_sel_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sel_onehot", 64'(sel_onehot), 64'(mon_e.onehot));
                check("sel_idx_at_commit", 64'(sel_idx), 64'(mon_e.idx));
                check("sel_timeout", 64'(sel_timeout), 64'(mon_e.tmo));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_btn(input logic [2:0] b);
        {confirm, nextMode, preMode} = b;
    endtask

    task automatic press(input logic [2:0] b);
        drive_btn(b);
        tick(8);
        drive_btn(3'b000);
        tick(12);
    endtask

    // Press with move latency check: unchanged 6 cycles after the raw edge, moved at 7
    task automatic press_chk(input logic [2:0] b, input int old_c, input int new_c);
        drive_btn(b);
        tick(6);
        check("cursor_before_move", 64'(cursor), 64'(old_c));
        tick(1);
        check("cursor_after_move", 64'(cursor), 64'(new_c));
        tick(1);
        drive_btn(3'b000);
        tick(12);
    endtask

    task automatic reopen();
        open = 1'b0;
        tick(2);
        open = 1'b1;
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0;
        open  = 1'b0;
        drive_btn(3'b000);
        tick(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sel_valid", 64'(sel_valid), 64'd0);
        check("rst_sel_onehot", 64'(sel_onehot), 64'd0);
        check("rst_sel_timeout", 64'(sel_timeout), 64'd0);
        check("rst_cursor", 64'(cursor), 64'(DEF_OPT));
        check("rst_sel_idx", 64'(sel_idx), 64'(DEF_OPT));
        check("rst_seg", 64'({Seg1, Seg2, Seg3, Seg4, Seg5, Seg6}), 64'(IDLE));
        rst_n = 1'b1;
        tick(2);

        // Open: busy next cycle, glyph one cycle later
        open = 1'b1;
        tick(1);
        check("open_busy", 64'(busy), 64'd1);
        check("open_cursor", 64'(cursor), 64'(DEF_OPT));
        check("open_seg_lag", 64'({Seg1, Seg2, Seg3, Seg4, Seg5, Seg6}), 64'(IDLE));
        tick(1);
        check("open_seg", 64'({Seg1, Seg2, Seg3, Seg4, Seg5, Seg6}), 64'(glyph(2)));

        press_chk(3'b010, 2, 3);
        press_chk(3'b010, 3, 0);
        press_chk(3'b010, 0, 1);
        check("seg_cursor1", 64'({Seg1, Seg2, Seg3, Seg4, Seg5, Seg6}), 64'(glyph(1)));

        press_chk(3'b001, 1, 0);
        press_chk(3'b001, 0, 3);
        check("seg_cursor3", 64'({Seg1, Seg2, Seg3, Seg4, Seg5, Seg6}), 64'(glyph(3)));
        sb_q.push_back('{onehot: 4'b1000, idx: 4'd3, tmo: 1'b0});
        press(3'b100);
        check("commit_drained", 64'(sb_q.size()), 64'd0);
        check("after_commit_busy", 64'(busy), 64'd0);
        check("after_commit_idx", 64'(sel_idx), 64'd3);
        check("after_commit_onehot", 64'(sel_onehot), 64'd0);
        check("after_commit_seg", 64'({Seg1, Seg2, Seg3, Seg4, Seg5, Seg6}), 64'(IDLE));

        // Contact bounce followed by a clean press gives one step
        reopen();
        check("reopen_cursor", 64'(cursor), 64'(DEF_OPT));
        repeat (3) begin
            nextMode = 1'b1;
            tick(1);
            nextMode = 1'b0;
            tick(1);
        end
        tick(6);
        check("bounce_no_move", 64'(cursor), 64'd2);
        press(3'b010);
        check("bounce_then_press", 64'(cursor), 64'd3);

        press(3'b010);
        press(3'b010);
        check("cursor_before_combo", 64'(cursor), 64'd1);
        sb_q.push_back('{onehot: 4'b0010, idx: 4'd1, tmo: 1'b0});
        press(3'b110);
        check("combo_drained", 64'(sb_q.size()), 64'd0);
        check("combo_cursor_still", 64'(cursor), 64'd1);

        reopen();
        press(3'b011);
        check("next_pre_cancel", 64'(cursor), 64'd2);

        open = 1'b0;
        tick(2);
        check("close_busy", 64'(busy), 64'd0);
        check("close_sel_idx", 64'(sel_idx), 64'd1);

        // Close arrives in the same cycle as the confirm event
        open = 1'b1;
        tick(2);
        confirm = 1'b1;
        tick(6);
        open = 1'b0;
        tick(2);
        confirm = 1'b0;
        tick(12);
        check("close_vs_confirm_busy", 64'(busy), 64'd0);
        check("close_vs_confirm_idx", 64'(sel_idx), 64'd1);

        reopen();
        press(3'b001);
        press(3'b001);
        check("cursor_before_idle", 64'(cursor), 64'd0);
`ifdef MENU_TIMEOUT_EN
        sb_q.push_back('{onehot: 4'b0100, idx: 4'd2, tmo: 1'b1});
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick(1);
        check("timeout_commit_seen", 64'(sb_q.size()), 64'd0);
        tick(2);
        check("timeout_busy", 64'(busy), 64'd0);
        check("timeout_cursor", 64'(cursor), 64'(DEF_OPT));
        check("timeout_sel_idx", 64'(sel_idx), 64'(DEF_OPT));
`else
        tick(1000);
        check("no_timeout_busy", 64'(busy), 64'd1);
        check("no_timeout_cursor", 64'(cursor), 64'd0);
        check("no_timeout_sel_idx", 64'(sel_idx), 64'd1);
`endif

        // Reset while browsing returns everything to reset values
        reopen();
        press(3'b010);
        rst_n = 1'b0;
        open  = 1'b0;
        tick(1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cursor", 64'(cursor), 64'(DEF_OPT));
        check("midrst_sel_idx", 64'(sel_idx), 64'(DEF_OPT));
        check("midrst_seg", 64'({Seg1, Seg2, Seg3, Seg4, Seg5, Seg6}), 64'(IDLE));
        rst_n = 1'b1;
        tick(3);
        check("midrst_stays_closed", 64'(busy), 64'd0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
